ama_riscv_rf_wb_arbiter: RTL

Shares the register file's single synchronous write port between several writeback requesters: the main pipeline writeback, multi-cycle units, and the debug write path. Each requester uses a valid/ready handshake. One requester is granted per cycle, and the winner's write is registered and presented to the register file's `we`/`addr_d`/`data_d` inputs on the next cycle. The block sits between the writeback sources and the register file, and is the only driver of its write port.

---
 rtl/ama_riscv_rf_wb_arbiter.sv | 102 ++++++++++
 1 files changed

// File: rtl/ama_riscv_rf_wb_arbiter.sv
// rtl/ama_riscv_rf_wb_arbiter.sv - arbitrates writeback requesters onto the single register file write port
// Optional: AMA_RISCV_RF_WB_FIXED_PRIO_EN selects fixed priority (requester 0 highest) instead of round-robin.
module ama_riscv_rf_wb_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int PTR_W   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hold,
    input  logic [NUM_REQ-1:0]      req_valid,
    input  logic [5*NUM_REQ-1:0]    req_addr,
    input  logic [32*NUM_REQ-1:0]   req_data,
    output logic [NUM_REQ-1:0]      req_ready,
    output logic                    rf_we,
    output logic [4:0]              rf_addr_d,
    output logic [31:0]             rf_data_d,
    output logic [PTR_W-1:0]        grant_id,
    output logic                    wb_busy
);

    logic             gnt_found;
    logic [PTR_W-1:0] gnt_idx;
    logic [4:0]       sel_addr;
    logic [31:0]      sel_data;
    logic [PTR_W-1:0] eff_ptr;

    logic             rf_we_q;
    logic [4:0]       rf_addr_q;
    logic [31:0]      rf_data_q;
    logic [PTR_W-1:0] grant_id_q;

`ifdef AMA_RISCV_RF_WB_FIXED_PRIO_EN
    assign eff_ptr = '0;
`else
    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    // Unreachable pointer values (NUM_REQ not a power of two) fall back to 0.
    assign eff_ptr = (int'(ptr_q) >= NUM_REQ) ? '0 : ptr_q;
    assign ptr_d   = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else if (gnt_found) begin
            ptr_q <= ptr_d;
        end
    end
`endif

    always_comb begin
        int cand;
        cand      = 0;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        sel_addr  = '0;
        sel_data  = '0;
        req_ready = '0;
        if (rst && !hold) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                cand = int'(eff_ptr) + k;
                if (cand >= NUM_REQ) begin
                    cand = cand - NUM_REQ;
                end
                for (int j = 0; j < NUM_REQ; j++) begin
                    if (!gnt_found && (j == cand) && req_valid[j]) begin
                        gnt_found    = 1'b1;
                        gnt_idx      = PTR_W'(j);
                        sel_addr     = req_addr[5*j +: 5];
                        sel_data     = req_data[32*j +: 32];
                        req_ready[j] = 1'b1;
                    end
                end
            end
        end
    end

    // Writes to x0 are consumed but never reach the register file.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we_q    <= 1'b0;
            rf_addr_q  <= '0;
            rf_data_q  <= '0;
            grant_id_q <= '0;
        end else begin
            rf_we_q <= 1'b0;
            if (gnt_found && (sel_addr != 5'd0)) begin
                rf_we_q    <= 1'b1;
                rf_addr_q  <= sel_addr;
                rf_data_q  <= sel_data;
                grant_id_q <= gnt_idx;
            end
        end
    end

    assign rf_we     = rf_we_q;
    assign rf_addr_d = rf_addr_q;
    assign rf_data_d = rf_data_q;
    assign grant_id  = grant_id_q;
    assign wb_busy   = (|req_valid) | rf_we_q;

endmodule
